rvga_console_arbiter: RTL and testbench
=======================================

// Module: rvga_console_arbiter
// PURPOSE
//  Shares the single console byte-write channel (MMIO console address) between num_req_p requesters
//  (harts, debug/loader). Round-robin arbitrates, buffers bytes in a FIFO, and sequences them to the
//  console sink (UART model or test monitor) with a valid/ready handshake.
//  Requests to non-console addresses are dropped and counted.
// PARAMETERS
//  num_req_p       2              number of requesters (>=1)
//  fifo_depth_p    8              FIFO entries; power of two, >=2
//  console_addr_p  32'h10000000   console MMIO byte address
// PORTS
//  clk_i         in   1              clock, rising edge
//  reset_n_i     in   1              asynchronous active-low reset
//  req_v_i       in   num_req_p      per-requester write valid
//  req_addr_i    in   num_req_p x32  per-requester write address
//  req_data_i    in   num_req_p x8   per-requester write byte
//  req_ready_o   out  num_req_p      per-requester accept (one-hot or zero)
//  out_v_o       out  1              byte valid to sink
//  out_addr_o    out  32             always console_addr_p
//  out_data_o    out  8              byte to sink
//  out_ready_i   in   1              sink accepts byte
//  drop_cnt_o    out  16             saturating count of dropped non-console writes
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, RR pointer=0, FSM=S_PASS, out_v_o=0, drop_cnt_o=0.
//  Arbitration (combinational): search from RR pointer upward (wrapping) for first req_v_i[i].
//   Winner gets req_ready_o[i]=1 if its addr!=console_addr_p (drop; no FIFO space needed)
//   or the FIFO is not full (registered full flag).
//   All other requesters see ready=0. Accept = req_v_i[i] & req_ready_o[i].
//  On accept: RR pointer <= winner+1 (mod num_req_p). Console write: push byte.
//   Drop: drop_cnt_o++ (holds at 16'hFFFF).
//  Requesters hold valid/addr/data stable until accepted; at most one accept per cycle.
//  Output: out_v_o = !empty; out_data_o = FIFO head (registered storage, no comb path from req_*).
//   Byte popped when out_v_o & out_ready_i. Latency: accepted byte visible on out_v_o next cycle
//   at earliest. out_v_o/out_data_o stable while out_ready_i=0.
//  Full with simultaneous pop: the pop proceeds; no push that cycle (ready uses registered full).
//   Empty with push: out_v_o rises next cycle.
//  Pointers are log2(fifo_depth_p) bits and wrap naturally. A separate count disambiguates full/empty.
//  Reset mid-transfer: pending FIFO bytes are discarded; no partial bytes are emitted.
// CONFIGURATION
//  `RVGA_CONSOLE_CRLF_EN defined: output FSM S_PASS/S_CR.
//   In S_PASS, if head==8'h0A, emit 8'h0D without popping. On its handshake go to S_CR.
//   In S_CR, emit 8'h0A; on its handshake pop and return to S_PASS. Other bytes pass through.
//  Not defined: pure pass-through; the FSM register is absent; the byte stream is unchanged.
// STRUCTURE
//  Package rvga_console_pkg: CHAR_LF/CHAR_CR constants, out_state_e enum, console_addr default.
//  Sub-module rvga_console_fifo (depth/width params, push/pop/full/empty/head).
//  Arbiter and FSM stay in this module.
// TESTING
//  1. Req0 writes "OK\n" alone, out_ready_i=1 -> sink sees 4F,4B,0A on consecutive cycles (0D before 0A with CRLF_EN).
//  2. Both requesters valid for 4 bytes each -> accepts alternate 0,1,0,1...; per-requester order preserved.
//  3. out_ready_i=0 until 8 accepted -> req_ready_o=0 on 9th; raise ready -> 8 bytes drain in order, then 9th accepted.
//  4. Req1 writes addr 32'h20000000 x3 -> req_ready_o[1]=1 each, no out_v_o, drop_cnt_o=3.
//  5. Assert reset_n_i low with 5 queued -> out_v_o=0 immediately; after release, no stale bytes.
//  6. Full FIFO, pop and new request same cycle -> pop occurs, push deferred one cycle, count=7 then 8.

Source files
------------

// File: rtl/rvga_console_pkg.sv
// Shared constants and types for the console arbiter slice.
package rvga_console_pkg;

    localparam logic [7:0]  CHAR_LF          = 8'h0A;
    localparam logic [7:0]  CHAR_CR          = 8'h0D;
    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;

    typedef enum logic {
        S_PASS = 1'b0,
        S_CR   = 1'b1
    } out_state_e;

endpackage

// File: rtl/rvga_console_fifo.sv
// Byte FIFO with registered full/empty flags; pointers wrap naturally, a count resolves full vs empty.
module rvga_console_fifo #(
    parameter int depth_p = 8,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [width_p-1:0] head_o
);

    localparam int PTR_W = $clog2(depth_p);
    localparam int CNT_W = PTR_W + 1;

    logic [width_p-1:0] mem_r [depth_p];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               full_r;
    logic               empty_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign push_ok_s = push_i & ~full_r;
    assign pop_ok_s  = pop_i & ~empty_r;
    assign full_o    = full_r;
    assign empty_o   = empty_r;
    assign head_o    = mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_W'(depth_p));
            empty_r <= (count_next_s == CNT_W'(0));
        end
    end

    // Byte storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/rvga_console_arbiter.sv
// Round-robin console byte arbiter with FIFO and sink handshake.
// Optional LF -> CR LF expansion when RVGA_CONSOLE_CRLF_EN is defined.
module rvga_console_arbiter
    import rvga_console_pkg::*;
#(
    parameter int          num_req_p      = 2,
    parameter int          fifo_depth_p   = 8,
    parameter logic [31:0] console_addr_p = CONSOLE_ADDR_DEF
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [num_req_p-1:0]   req_v_i,
    input  logic [num_req_p*32-1:0] req_addr_i,
    input  logic [num_req_p*8-1:0] req_data_i,
    output logic [num_req_p-1:0]   req_ready_o,
    output logic                   out_v_o,
    output logic [31:0]            out_addr_o,
    output logic [7:0]             out_data_o,
    input  logic                   out_ready_i,
    output logic [15:0]            drop_cnt_o
);

    localparam int IDX_W = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic [IDX_W-1:0] rr_r;
    logic [IDX_W-1:0] win_s;
    logic [IDX_W-1:0] rr_next_s;
    logic             found_s;
    logic [31:0]      win_addr_s;
    logic [7:0]       win_data_s;
    logic             is_console_s;
    logic             grant_s;
    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       head_s;
    logic [15:0]      drop_cnt_r;

    // Search upward from the round-robin pointer for the first valid requester.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        found_s = 1'b0;
        win_s   = rr_r;
        for (int k = 0; k < num_req_p; k++) begin
            idx = (int'(rr_r) + k) % num_req_p;
            if (!found_s && req_v_i[idx]) begin
                found_s = 1'b1;
                win_s   = IDX_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign win_addr_s   = req_addr_i[int'(win_s)*32 +: 32];
    assign win_data_s   = req_data_i[int'(win_s)*8 +: 8];
    assign is_console_s = (win_addr_s == console_addr_p);
    // Drops never need FIFO space; console bytes wait on the registered full flag.
    assign grant_s      = found_s & (~is_console_s | ~fifo_full_s);
    assign push_s       = grant_s & is_console_s;
    assign drop_s       = grant_s & ~is_console_s;
    assign rr_next_s    = (int'(win_s) == num_req_p - 1) ? '0 : win_s + IDX_W'(1);

    // One-hot ready to the winner only.
    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            req_ready_o[i] = grant_s & (win_s == IDX_W'(i));
        end
    end

    // Round-robin pointer advances past each accepted requester.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_r <= '0;
        end else if (grant_s) begin
            rr_r <= rr_next_s;
        end
    end

    // Saturating count of non-console writes.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    rvga_console_fifo #(
        .depth_p (fifo_depth_p),
        .width_p (8)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push_s),
        .data_i    (win_data_s),
        .pop_i     (pop_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .head_o    (head_s)
    );

    assign out_v_o    = ~fifo_empty_s;
    assign out_addr_o = console_addr_p;
    assign drop_cnt_o = drop_cnt_r;

`ifdef RVGA_CONSOLE_CRLF_EN
    out_state_e state_r;
    out_state_e state_next_s;
    logic       hs_s;

    assign hs_s = out_v_o & out_ready_i;

    // Output sequencing state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= S_PASS;
        end else begin
            state_r <= state_next_s;
        end
    end

    // An LF at the head is sent as CR first, then LF, and only then popped.
    always_comb begin
        state_next_s = state_r;
        out_data_o   = head_s;
        pop_s        = 1'b0;
        case (state_r)
            S_PASS: begin
                if (head_s == CHAR_LF) begin
                    out_data_o   = CHAR_CR;
                    state_next_s = hs_s ? S_CR : S_PASS;
                end else begin
                    pop_s = hs_s;
                end
            end
            S_CR: begin
                out_data_o = CHAR_LF;
                if (hs_s) begin
                    pop_s        = 1'b1;
                    state_next_s = S_PASS;
                end else begin
                    state_next_s = S_CR;
                end
            end
            default: begin
                state_next_s = S_PASS;
            end
        endcase
    end
`else
    assign out_data_o = head_s;
    assign pop_s      = out_v_o & out_ready_i;
`endif

endmodule

// File: tb/tb_rvga_console_arbiter.sv
// Self-checking bench for rvga_console_arbiter (default build) against a queue-based reference model.
module tb_rvga_console_arbiter;

    localparam logic [31:0] CON   = 32'h1000_0000;
    localparam logic [31:0] OTHER = 32'h2000_0000;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [1:0]  req_v_i;
    logic [63:0] req_addr_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_ready_o;
    logic        out_v_o;
    logic [31:0] out_addr_o;
    logic [7:0]  out_data_o;
    logic        out_ready_i;
    logic [15:0] drop_cnt_o;

    rvga_console_arbiter dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .req_v_i     (req_v_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .out_v_o     (out_v_o),
        .out_addr_o  (out_addr_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int tests_run    = 0;
    int tests_failed = 0;

    // Requester streams {addr, byte}, model FIFO, and bytes seen at the sink.
    logic [39:0] src0_q[$];
    logic [39:0] src1_q[$];
    logic [7:0]  mq[$];
    logic [7:0]  sink_log[$];
    int          m_rr;
    int          m_drop;

    logic [1:0]  exp_rdy, obs_rdy;
    logic        exp_v, obs_v;
    logic [7:0]  exp_d, obs_d;
    logic [15:0] exp_drop, obs_drop;
    logic [31:0] obs_addr;

    task automatic apply_reset();
        reset_n_i   = 1'b0;
        req_v_i     = 2'b00;
        req_addr_i  = 64'h0;
        req_data_i  = 16'h0;
        out_ready_i = 1'b0;
        src0_q.delete(); src1_q.delete(); mq.delete(); sink_log.delete();
        m_rr = 0; m_drop = 0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    // One clock: drive heads of the request streams, predict, sample, advance the model.
    task automatic step(input logic rdy);
        logic [1:0]  v;
        logic [39:0] h0, h1, hw;
        int          win;
        v  = {src1_q.size() != 0, src0_q.size() != 0};
        h0 = v[0] ? src0_q[0] : 40'h0;
        h1 = v[1] ? src1_q[0] : 40'h0;
        req_v_i     = v;
        req_addr_i  = {h1[39:8], h0[39:8]};
        req_data_i  = {h1[7:0], h0[7:0]};
        out_ready_i = rdy;
        win = -1;
        for (int k = 0; k < 2; k++) if (win < 0 && v[(m_rr + k) % 2]) win = (m_rr + k) % 2;
        hw = (win == 1) ? h1 : h0;
        exp_rdy = 2'b00;
        if (win >= 0 && (hw[39:8] != CON || mq.size() < 8)) exp_rdy[win] = 1'b1;
        exp_v    = (mq.size() != 0);
        exp_d    = exp_v ? mq[0] : 8'h00;
        exp_drop = 16'(m_drop);
        #1;
        obs_rdy = req_ready_o; obs_v = out_v_o; obs_d = out_data_o; obs_drop = drop_cnt_o; obs_addr = out_addr_o;
        if (obs_v === 1'b1 && rdy) sink_log.push_back(obs_d);
        @(posedge clk_i);
        if (exp_v && rdy) void'(mq.pop_front());
        if (exp_rdy != 2'b00) begin
            if (win == 1) void'(src1_q.pop_front()); else void'(src0_q.pop_front());
            if (hw[39:8] == CON) mq.push_back(hw[7:0]);
            else if (m_drop < 65535) m_drop++;
            m_rr = (win + 1) % 2;
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests_run++;
        if (out_v_o !== 1'b0) begin tests_failed++; $display("FAIL reset_out_v: got %b want 0", out_v_o); end
        tests_run++;
        if (drop_cnt_o !== 16'h0000) begin tests_failed++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
        tests_run++;
        if (req_ready_o !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b want 00", req_ready_o); end
        tests_run++;
        if (out_addr_o !== CON) begin tests_failed++; $display("FAIL out_addr: got %h want %h", out_addr_o, CON); end
        @(negedge clk_i);
    endtask

    task automatic test_ok_string();
        logic [7:0] exp_s [3];
        exp_s = '{8'h4F, 8'h4B, 8'h0A};
        apply_reset();
        for (int i = 0; i < 3; i++) src0_q.push_back({CON, exp_s[i]});
        for (int c = 0; c < 6; c++) begin
            step(1'b1);
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_v !== exp_v || (exp_v && obs_d !== exp_d) || obs_drop !== exp_drop) begin
                tests_failed++;
                $display("FAIL ok_cycle %0d: got rdy=%b v=%b d=%h drop=%0d, want rdy=%b v=%b d=%h drop=%0d", c, obs_rdy, obs_v, obs_d, obs_drop, exp_rdy, exp_v, exp_d, exp_drop);
            end
        end
        tests_run++;
        if (sink_log.size() != 3) begin tests_failed++; $display("FAIL ok_count: got %0d want 3", sink_log.size()); end
        else for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (sink_log[i] !== exp_s[i]) begin tests_failed++; $display("FAIL ok_byte %0d: got %h want %h", i, sink_log[i], exp_s[i]); end
        end
    endtask

    task automatic test_alternation();
        logic [7:0] want;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            src0_q.push_back({CON, 8'hA0 + 8'(i)});
            src1_q.push_back({CON, 8'hB0 + 8'(i)});
        end
        for (int c = 0; c < 12; c++) begin
            step(1'b1);
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_v !== exp_v || (exp_v && obs_d !== exp_d) || obs_drop !== exp_drop) begin
                tests_failed++;
                $display("FAIL alt_cycle %0d: got rdy=%b v=%b d=%h drop=%0d, want rdy=%b v=%b d=%h drop=%0d", c, obs_rdy, obs_v, obs_d, obs_drop, exp_rdy, exp_v, exp_d, exp_drop);
            end
        end
        tests_run++;
        if (sink_log.size() != 8) begin tests_failed++; $display("FAIL alt_count: got %0d want 8", sink_log.size()); end
        else for (int i = 0; i < 8; i++) begin
            want = (i % 2 == 0) ? 8'hA0 + 8'(i / 2) : 8'hB0 + 8'(i / 2);
            tests_run++;
            if (sink_log[i] !== want) begin tests_failed++; $display("FAIL alt_byte %0d: got %h want %h", i, sink_log[i], want); end
        end
    endtask

    task automatic test_backpressure();
        int budget;
        apply_reset();
        for (int i = 0; i < 9; i++) src0_q.push_back({CON, 8'h10 + 8'(i)});
        for (int c = 0; c < 9; c++) begin
            step(1'b0);
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_v !== exp_v || (exp_v && obs_d !== exp_d) || obs_drop !== exp_drop) begin
                tests_failed++;
                $display("FAIL bp_fill %0d: got rdy=%b v=%b d=%h, want rdy=%b v=%b d=%h", c, obs_rdy, obs_v, obs_d, exp_rdy, exp_v, exp_d);
            end
        end
        tests_run++;
        if (obs_rdy !== 2'b00) begin tests_failed++; $display("FAIL bp_ninth_ready: got %b want 00", obs_rdy); end
        budget = 0;
        while ((src0_q.size() != 0 || mq.size() != 0) && budget < 30) begin
            step(1'b1);
            budget++;
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin
                tests_failed++;
                $display("FAIL bp_drain %0d: got rdy=%b v=%b d=%h, want rdy=%b v=%b d=%h", budget, obs_rdy, obs_v, obs_d, exp_rdy, exp_v, exp_d);
            end
        end
        tests_run++;
        if (budget >= 30) begin tests_failed++; $display("FAIL bp_timeout: got %0d cycles want <30", budget); end
        tests_run++;
        if (sink_log.size() != 9) begin tests_failed++; $display("FAIL bp_count: got %0d want 9", sink_log.size()); end
        else for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (sink_log[i] !== 8'h10 + 8'(i)) begin tests_failed++; $display("FAIL bp_byte %0d: got %h want %h", i, sink_log[i], 8'h10 + 8'(i)); end
        end
    endtask

    task automatic test_drop();
        apply_reset();
        for (int i = 0; i < 3; i++) src1_q.push_back({OTHER, 8'h55});
        for (int c = 0; c < 5; c++) begin
            step(1'b1);
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_v !== exp_v || obs_drop !== exp_drop) begin
                tests_failed++;
                $display("FAIL drop_cycle %0d: got rdy=%b v=%b drop=%0d, want rdy=%b v=%b drop=%0d", c, obs_rdy, obs_v, obs_drop, exp_rdy, exp_v, exp_drop);
            end
        end
        #1;
        tests_run++;
        if (drop_cnt_o !== 16'd3) begin tests_failed++; $display("FAIL drop_total: got %0d want 3", drop_cnt_o); end
        tests_run++;
        if (sink_log.size() != 0) begin tests_failed++; $display("FAIL drop_sink: got %0d bytes want 0", sink_log.size()); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) src0_q.push_back({CON, 8'h30 + 8'(i)});
        for (int c = 0; c < 5; c++) begin
            step(1'b0);
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_v !== exp_v || (exp_v && obs_d !== exp_d)) begin
                tests_failed++;
                $display("FAIL rst_fill %0d: got rdy=%b v=%b d=%h, want rdy=%b v=%b d=%h", c, obs_rdy, obs_v, obs_d, exp_rdy, exp_v, exp_d);
            end
        end
        reset_n_i = 1'b0;
        #1;
        tests_run++;
        if (out_v_o !== 1'b0) begin tests_failed++; $display("FAIL rst_immediate: got out_v=%b want 0", out_v_o); end
        src0_q.delete(); mq.delete(); sink_log.delete(); m_rr = 0; m_drop = 0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1'b1);
            tests_run++;
            if (obs_v !== 1'b0 || obs_rdy !== 2'b00 || obs_drop !== 16'h0) begin
                tests_failed++;
                $display("FAIL rst_stale %0d: got v=%b rdy=%b drop=%0d want 0", c, obs_v, obs_rdy, obs_drop);
            end
        end
        tests_run++;
        if (sink_log.size() != 0) begin tests_failed++; $display("FAIL rst_sink: got %0d bytes want 0", sink_log.size()); end
    endtask

    task automatic test_full_pop_push();
        apply_reset();
        for (int i = 0; i < 9; i++) src0_q.push_back({CON, 8'h60 + 8'(i)});
        repeat (8) step(1'b0);
        step(1'b1);
        tests_run++;
        if (obs_rdy !== 2'b00 || obs_v !== 1'b1 || obs_d !== 8'h60) begin
            tests_failed++; $display("FAIL full_pop: got rdy=%b v=%b d=%h want rdy=00 v=1 d=60", obs_rdy, obs_v, obs_d);
        end
        step(1'b0);
        tests_run++;
        if (obs_rdy !== 2'b01 || obs_d !== 8'h61) begin
            tests_failed++; $display("FAIL full_deferred_push: got rdy=%b d=%h want rdy=01 d=61", obs_rdy, obs_d);
        end
        src0_q.push_back({CON, 8'h70});
        step(1'b0);
        tests_run++;
        if (obs_rdy !== 2'b00) begin tests_failed++; $display("FAIL full_again: got rdy=%b want 00", obs_rdy); end
    endtask

    task automatic test_random();
        int budget;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (src0_q.size() < 3 && $urandom_range(0, 2) == 0)
                src0_q.push_back({($urandom_range(0, 3) == 0) ? OTHER : CON, 8'($urandom)});
            if (src1_q.size() < 3 && $urandom_range(0, 2) == 0)
                src1_q.push_back({($urandom_range(0, 3) == 0) ? OTHER : CON, 8'($urandom)});
            step(1'($urandom_range(0, 1)));
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_v !== exp_v || (exp_v && obs_d !== exp_d) || obs_drop !== exp_drop) begin
                tests_failed++;
                $display("FAIL rand_cycle %0d: got rdy=%b v=%b d=%h drop=%0d, want rdy=%b v=%b d=%h drop=%0d", c, obs_rdy, obs_v, obs_d, obs_drop, exp_rdy, exp_v, exp_d, exp_drop);
            end
        end
        budget = 0;
        while ((src0_q.size() != 0 || src1_q.size() != 0 || mq.size() != 0) && budget < 40) begin
            step(1'b1);
            budget++;
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_v !== exp_v || (exp_v && obs_d !== exp_d) || obs_drop !== exp_drop) begin
                tests_failed++;
                $display("FAIL rand_drain %0d: got rdy=%b v=%b d=%h, want rdy=%b v=%b d=%h", budget, obs_rdy, obs_v, obs_d, exp_rdy, exp_v, exp_d);
            end
        end
        tests_run++;
        if (budget >= 40) begin tests_failed++; $display("FAIL rand_timeout: got %0d cycles want <40", budget); end
    endtask

    initial begin
        test_reset();
        test_ok_string();
        test_alternation();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_full_pop_push();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
